// File: rtl/snac_pkg.sv
// Shared definitions for the SNAC DB15 receiver: FSM states, pad bit positions
// and default build parameters.
package snac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SAMPLE,
        ST_SHIFT,
        ST_CHECK,
        ST_GAP
    } snac_st_t;

    // Bit positions inside one player's word.
    localparam int SNAC_RIGHT  = 0;
    localparam int SNAC_LEFT   = 1;
    localparam int SNAC_DOWN   = 2;
    localparam int SNAC_UP     = 3;
    localparam int SNAC_A      = 4;
    localparam int SNAC_B      = 5;
    localparam int SNAC_C      = 6;
    localparam int SNAC_X      = 7;
    localparam int SNAC_Y      = 8;
    localparam int SNAC_Z      = 9;
    localparam int SNAC_START  = 10;
    localparam int SNAC_SELECT = 11;

    localparam int SNAC_CLK_DIV  = 24;
    localparam int SNAC_NBITS    = 12;
    localparam int SNAC_SCAN_GAP = 64;

endpackage

// File: rtl/snac_tick.sv
// Bit-tick divider: one-cycle o_tick every CLK_DIV clocks, restarted by i_reset.
module snac_tick
    import snac_pkg::*;
#(
    parameter int CLK_DIV = SNAC_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int              CW       = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == CNT_LAST);
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/snac_db15_rx.sv
// SNAC DB15 pad receiver: scans the 74HC165 chain, accepts a scan only when it
// matches the previous one, and publishes active-high player words.
module snac_db15_rx
    import snac_pkg::*;
#(
    parameter int CLK_DIV  = SNAC_CLK_DIV,
    parameter int NBITS    = SNAC_NBITS,
    parameter int SCAN_GAP = SNAC_SCAN_GAP
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        valid
);

    localparam int            CHAIN    = 2 * NBITS;
    localparam int            BW       = $clog2(CHAIN);
    localparam int            GW       = (SCAN_GAP < 1) ? 1 : $clog2(SCAN_GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP);

    logic             w_tick;
    snac_st_t         r_state;
    snac_st_t         w_state_nxt;
    logic [BW-1:0]    r_bitcnt;
    logic [GW-1:0]    r_gapcnt;
    logic [CHAIN-1:0] r_shreg;
    logic [CHAIN-1:0] r_prev;
    logic             r_joy_clk;
    logic             r_joy_load_n;
    logic [15:0]      r_joy1;
    logic [15:0]      r_joy2;
    logic             r_valid;
    logic [15:0]      w_joy1;
    logic [15:0]      w_joy2;

    snac_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: defaulting every always_comb output first keeps this a pure mux, no latch.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_LOAD;
                ST_LOAD:   w_state_nxt = ST_SAMPLE;
                ST_SAMPLE: w_state_nxt = ST_SHIFT;
                ST_SHIFT:  w_state_nxt = (r_bitcnt == BIT_LAST) ? ST_CHECK : ST_SAMPLE;
                ST_CHECK:  w_state_nxt = ST_GAP;
                ST_GAP:    if (r_gapcnt == GAP_LAST) w_state_nxt = ST_LOAD;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Player words zero-extended from the raw chain; only latched on a confirmed scan.
    always_comb begin
        w_joy1 = '0;
        w_joy2 = '0;
        w_joy1[NBITS-1:0] = r_shreg[NBITS-1:0];
        w_joy2[NBITS-1:0] = r_shreg[CHAIN-1:NBITS];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bitcnt     <= '0;
            r_gapcnt     <= '0;
            r_shreg      <= '0;
            r_prev       <= '0;
            r_joy_clk    <= 1'b0;
            r_joy_load_n <= 1'b1;
            r_joy1       <= '0;
            r_joy2       <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: r_joy_load_n <= 1'b0;
                    ST_LOAD: begin
                        r_joy_load_n <= 1'b1;
                        r_bitcnt     <= '0;
                    end
                    ST_SAMPLE: begin
                        r_shreg[r_bitcnt] <= ~JOY_DATA;
                        r_joy_clk         <= 1'b1;
                    end
                    ST_SHIFT: begin
                        r_joy_clk <= 1'b0;
                        r_bitcnt  <= r_bitcnt + BW'(1);
                    end
                    ST_CHECK: begin
                        if (r_shreg == r_prev) begin
                            r_joy1  <= w_joy1;
                            r_joy2  <= w_joy2;
                            r_valid <= 1'b1;
                        end
                        r_prev   <= r_shreg;
                        r_gapcnt <= '0;
                    end
                    ST_GAP: begin
                        if (r_gapcnt == GAP_LAST) r_joy_load_n <= 1'b0;
                        else                      r_gapcnt     <= r_gapcnt + GW'(1);
                    end
                    default: r_joy_load_n <= 1'b1;
                endcase
            end
        end
    end

    assign JOY_CLK   = r_joy_clk;
    assign JOY_LOAD  = r_joy_load_n;
    assign joystick1 = r_joy1;
    assign joystick2 = r_joy2;
    assign valid     = r_valid;

endmodule

// File: tb/tb_snac_db15_rx.sv
// Bench for snac_db15_rx: behavioural 74HC165 chains feed a 12-bit and an 8-bit build.
module tb_snac_db15_rx;
    import snac_pkg::*;

    localparam int CD      = 4;
    localparam int NB_A    = 12;
    localparam int NB_B    = 8;
    localparam int GAP     = 8;
    localparam int TICKS_A = 1 + 1 + 4 * NB_A + 1 + GAP;
    localparam int PER_A   = TICKS_A * CD;
    localparam int PER_B   = (1 + 1 + 4 * NB_B + 1 + GAP) * CD;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    // Build A (12 bits/player)
    logic        joy_data_a, joy_clk_a, joy_load_a, valid_a;
    logic [15:0] j1_a, j2_a;
    logic [11:0] p1_a, p2_a;
    logic [23:0] chain_a = '1;

    // Build B (8 bits/player)
    logic        joy_data_b, joy_clk_b, joy_load_b, valid_b;
    logic [15:0] j1_b, j2_b;
    logic [7:0]  p1_b, p2_b;
    logic [15:0] chain_b = '1;

    snac_db15_rx #(.CLK_DIV(CD), .NBITS(NB_A), .SCAN_GAP(GAP)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .JOY_DATA(joy_data_a), .JOY_CLK(joy_clk_a),
        .JOY_LOAD(joy_load_a), .joystick1(j1_a), .joystick2(j2_a), .valid(valid_a));

    snac_db15_rx #(.CLK_DIV(CD), .NBITS(NB_B), .SCAN_GAP(GAP)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .JOY_DATA(joy_data_b), .JOY_CLK(joy_clk_b),
        .JOY_LOAD(joy_load_b), .joystick1(j1_b), .joystick2(j2_b), .valid(valid_b));

    // 74HC165 chains: buttons pull low, serial-in tied high, bit 0 nearest the receiver.
    always @(posedge joy_clk_a or negedge joy_load_a)
        if (!joy_load_a) chain_a <= ~{p2_a, p1_a};
        else             chain_a <= {1'b1, chain_a[23:1]};
    assign joy_data_a = chain_a[0];

    always @(posedge joy_clk_b or negedge joy_load_b)
        if (!joy_load_b) chain_b <= ~{p2_b, p1_b};
        else             chain_b <= {1'b1, chain_b[15:1]};
    assign joy_data_b = chain_b[0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid_a(input int budget, output bit found, output int cycles);
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk_sys);
            cycles++;
            if (valid_a) found = 1'b1;
        end
    endtask

    task automatic count_valid_a(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_sys);
            if (valid_a) cnt++;
        end
    endtask

    // Waveform monitor on build A, sampled on the falling clk_sys edge.
    bit   mon_en = 1'b0;
    logic prev_clk, prev_load;
    bit   clk_primed, load_primed, scan_primed;
    int   clk_run, load_run, rises, per_run, rise_in_load;
    int   hi_min, hi_max, lo_min, lo_max, ld_min, ld_max, rps_min, rps_max, per_min, per_max;

    always @(negedge clk_sys) begin
        if (!mon_en) begin
            clk_primed = 0; load_primed = 0; scan_primed = 0;
            clk_run = 0; load_run = 0; rises = 0; per_run = 0; rise_in_load = 0;
            hi_min = 1000000; lo_min = 1000000; ld_min = 1000000; rps_min = 1000000; per_min = 1000000;
            hi_max = 0; lo_max = 0; ld_max = 0; rps_max = 0; per_max = 0;
        end else begin
            per_run++;
            if (joy_clk_a !== prev_clk) begin
                if (prev_clk) begin
                    if (clk_primed) begin
                        if (clk_run < hi_min) hi_min = clk_run;
                        if (clk_run > hi_max) hi_max = clk_run;
                    end
                end else begin
                    if (clk_primed && rises > 0) begin
                        if (clk_run < lo_min) lo_min = clk_run;
                        if (clk_run > lo_max) lo_max = clk_run;
                    end
                    rises++;
                    if (!joy_load_a) rise_in_load++;
                end
                clk_primed = 1;
                clk_run    = 1;
            end else begin
                clk_run++;
            end
            if (joy_load_a !== prev_load) begin
                if (!joy_load_a) begin
                    if (scan_primed) begin
                        if (rises < rps_min) rps_min = rises;
                        if (rises > rps_max) rps_max = rises;
                        if (per_run < per_min) per_min = per_run;
                        if (per_run > per_max) per_max = per_run;
                    end
                    scan_primed = 1;
                    rises       = 0;
                    per_run     = 0;
                end else if (load_primed) begin
                    if (load_run < ld_min) ld_min = load_run;
                    if (load_run > ld_max) ld_max = load_run;
                end
                load_primed = 1;
                load_run    = 1;
            end else begin
                load_run++;
            end
        end
        prev_clk  = joy_clk_a;
        prev_load = joy_load_a;
    end

    typedef struct {
        logic [11:0] p1;
        logic [11:0] p2;
        logic [15:0] e1;
        logic [15:0] e2;
        int          ev;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        int   cyc, cnt, changes, steps, rb;
        logic pc;

        vecs[0] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000, 1};
        vecs[1] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000, 2};
        vecs[2] = '{12'h000, 12'((1 << SNAC_SELECT) | (1 << SNAC_Z) | (1 << SNAC_LEFT)),
                    16'h0000, 16'h0A02, 1};
        vecs[3] = '{12'((1 << SNAC_DOWN) | (1 << SNAC_B) | (1 << SNAC_X)),
                    12'((1 << SNAC_C) | (1 << SNAC_Y)), 16'h00A4, 16'h0140, 1};
        vecs[4] = '{12'((1 << SNAC_UP) | (1 << SNAC_A)),
                    12'((1 << SNAC_START) | (1 << SNAC_RIGHT)), 16'h0018, 16'h0401, 1};

        p1_a = 12'((1 << SNAC_UP) | (1 << SNAC_A));
        p2_a = 12'((1 << SNAC_START) | (1 << SNAC_RIGHT));
        p1_b = 8'hFF;
        p2_b = 8'hFF;

        // Reset held for 10 cycles
        reset = 1'b1;
        @(posedge clk_sys);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            check("reset_state", {29'b0, joy_load_a, joy_clk_a, valid_a, j1_a, j2_a},
                  {29'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000});
        end
        reset = 1'b0;

        // Static pads confirmed after two scans, then one valid per scan period
        wait_valid_a(3 * PER_A + 50, found, cyc);
        check("static_valid_seen", found, 1);
        check("static_j1", j1_a, 16'h0018);
        check("static_j2", j2_a, 16'h0401);
        mon_en = 1'b1;
        wait_valid_a(PER_A + 10, found, cyc);
        check("period_valid_seen", found, 1);
        check("scan_period_cycles", cyc, PER_A);

        // Table of pad patterns, each applied right after a confirmed scan
        for (int i = 0; i < 5; i++) begin
            wait_valid_a(3 * PER_A, found, cyc);
            check("vec_sync", found, 1);
            p1_a = vecs[i].p1;
            p2_a = vecs[i].p2;
            count_valid_a(2 * PER_A + 10, cnt);
            check($sformatf("vec%0d_valids", i), cnt, vecs[i].ev);
            check($sformatf("vec%0d_j1", i), j1_a, vecs[i].e1);
            check($sformatf("vec%0d_j2", i), j2_a, vecs[i].e2);
        end

        // Glitch: one chain bit flipped for a single load only
        wait_valid_a(3 * PER_A, found, cyc);
        check("glitch_sync", found, 1);
        p1_a = vecs[4].p1 | 12'(1 << SNAC_Y);
        steps = 0;
        while (joy_load_a && steps < PER_A) begin @(negedge clk_sys); steps++; end
        while (!joy_load_a && steps < PER_A) begin @(negedge clk_sys); steps++; end
        check("glitch_load_seen", steps < PER_A, 1);
        p1_a = vecs[4].p1;
        cnt = 0;
        changes = 0;
        for (int k = 0; k < 2 * PER_A; k++) begin
            @(negedge clk_sys);
            if (valid_a) cnt++;
            if (j1_a !== 16'h0018 || j2_a !== 16'h0401) changes++;
        end
        check("glitch_no_valid", cnt, 0);
        check("glitch_outputs_held", changes, 0);
        wait_valid_a(PER_A + 10, found, cyc);
        check("glitch_recovered", found, 1);
        check("glitch_rec_j1", j1_a, 16'h0018);
        check("glitch_rec_j2", j2_a, 16'h0401);

        // Waveform figures gathered since the first confirmed scan
        mon_en = 1'b0;
        check("clk_high_min", hi_min, CD);
        check("clk_high_max", hi_max, CD);
        check("clk_low_min", lo_min, CD);
        check("clk_low_max", lo_max, CD);
        check("load_low_min", ld_min, CD);
        check("load_low_max", ld_max, CD);
        check("rises_per_scan_min", rps_min, 2 * NB_A);
        check("rises_per_scan_max", rps_max, 2 * NB_A);
        check("load_period_min", per_min, PER_A);
        check("load_period_max", per_max, PER_A);
        check("rise_during_load", rise_in_load, 0);

        // NBITS=8 build, all buttons pressed
        found = 1'b0;
        steps = 0;
        while (!found && steps < 3 * PER_B) begin
            @(negedge clk_sys); steps++;
            if (valid_b) found = 1'b1;
        end
        check("b_valid_seen", found, 1);
        check("b_j1", j1_b, 16'h00FF);
        check("b_j2", j2_b, 16'h00FF);
        steps = 0;
        while (joy_load_b && steps < 2 * PER_B) begin @(negedge clk_sys); steps++; end
        pc = joy_clk_b;
        rb = 0;
        @(negedge clk_sys);
        while (!(joy_load_b === 1'b0 && rb > 0) && steps < 2 * PER_B) begin
            if (joy_clk_b && !pc) rb++;
            pc = joy_clk_b;
            @(negedge clk_sys); steps++;
        end
        check("b_bounded", steps < 2 * PER_B, 1);
        check("b_rises_per_scan", rb, 2 * NB_B);

        // Reset while bit 13 is in flight
        steps = 0;
        while (joy_load_a && steps < 2 * PER_A) begin @(negedge clk_sys); steps++; end
        pc = joy_clk_a;
        rb = 0;
        while (rb < 13 && steps < 2 * PER_A) begin
            @(negedge clk_sys); steps++;
            if (joy_clk_a && !pc) rb++;
            pc = joy_clk_a;
        end
        check("midreset_reached_bit13", rb, 13);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midreset_state", {29'b0, joy_load_a, joy_clk_a, valid_a, j1_a, j2_a},
              {29'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000});
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        wait_valid_a(4 * PER_A, found, cyc);
        check("midreset_valid_seen", found, 1);
        check("midreset_two_scans", cyc > PER_A, 1);
        check("midreset_j1", j1_a, 16'h0018);
        check("midreset_j2", j2_a, 16'h0401);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
